// File: rtl/spart_driver_pkg.sv
// Shared types and constants for the SPART driver: FSM states, bus address map,
// baud divisors for a 100 MHz clock and the bus command payload.
package spart_driver_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CFG_W  = 2;
    localparam int unsigned DIV_W  = 16;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        IDLE,
        READ_RX,
        WAIT_TBR,
        WRITE_TX
    } state_t;

    typedef logic [ADDR_W-1:0] ioaddr_t;

    localparam ioaddr_t ADDR_BUF    = 2'b00;
    localparam ioaddr_t ADDR_STATUS = 2'b01;
    localparam ioaddr_t ADDR_DIV_LO = 2'b10;
    localparam ioaddr_t ADDR_DIV_HI = 2'b11;

    localparam logic [DIV_W-1:0] DIV_4800  = 16'd1302;
    localparam logic [DIV_W-1:0] DIV_9600  = 16'd651;
    localparam logic [DIV_W-1:0] DIV_19200 = 16'd326;
    localparam logic [DIV_W-1:0] DIV_38400 = 16'd163;

    // One registered bus cycle: chip select, direction, address and write data
    typedef struct packed {
        logic              cs;
        logic              rw;
        ioaddr_t           addr;
        logic [DATA_W-1:0] data;
    } bus_cmd_t;

    localparam bus_cmd_t CMD_IDLE = '{cs: 1'b0, rw: 1'b1, addr: ADDR_STATUS, data: '0};

    function automatic logic [DIV_W-1:0] div_lookup(input logic [CFG_W-1:0] cfg);
        case (cfg)
            2'b00:   return DIV_4800;
            2'b01:   return DIV_9600;
            2'b10:   return DIV_19200;
            default: return DIV_38400;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] div_lo(input logic [CFG_W-1:0] cfg);
        return DATA_W'(div_lookup(cfg));
    endfunction

    function automatic logic [DATA_W-1:0] div_hi(input logic [CFG_W-1:0] cfg);
        return DATA_W'(div_lookup(cfg) >> DATA_W);
    endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control/handshake signals between the SPART driver (master) and the SPART (slave).
interface spart_driver_if;

    logic                       rda;
    logic                       tbr;
    logic                       iocs;
    logic                       iorw;
    spart_driver_pkg::ioaddr_t  ioaddr;

    modport master (input rda, tbr, output iocs, iorw, ioaddr);
    modport slave  (output rda, tbr, input iocs, iorw, ioaddr);

endinterface

// File: rtl/br_sync.sv
// Two-flop synchronizer for the asynchronous baud-select switches.
module br_sync
    import spart_driver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CFG_W-1:0] d,
    output logic [CFG_W-1:0] q
);

    logic [CFG_W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor from the board switches, then echoes
// every received character back out through the transmitter.
module spart_driver
    import spart_driver_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [CFG_W-1:0]   br_cfg,
    spart_driver_if.master     bus,
    inout  wire  [DATA_W-1:0]  databus,
    output logic               overrun
);

    state_t            state;
    state_t            next_state;
    logic [CFG_W-1:0]  cfg_sync;
    logic [CFG_W-1:0]  prog_cfg;
    logic [1:0]        wake_q;
    logic              ready;
    logic              next_ready;
    logic              pend;
    logic [DATA_W-1:0] char_reg;
    bus_cmd_t          cmd_c;
    bus_cmd_t          cmd_q;

    br_sync u_br_sync (
        .clk (clk),
        .rst (rst),
        .d   (br_cfg),
        .q   (cfg_sync)
    );

    // Hold off the first divisor write until the synchronizer carries the real switch value
    assign ready      = (wake_q == 2'd3);
    assign next_ready = (wake_q >= 2'd2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT_LO;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT_LO:  if (ready) next_state = INIT_HI;
            INIT_HI:  next_state = IDLE;
            IDLE: begin
                if (bus.rda || pend)         next_state = READ_RX;
                else if (cfg_sync != prog_cfg) next_state = INIT_LO;
            end
            READ_RX:  next_state = WAIT_TBR;
            WAIT_TBR: if (bus.tbr) next_state = WRITE_TX;
            WRITE_TX: next_state = IDLE;
            default:  next_state = INIT_LO;
        endcase
    end

    // Bus cycle for the state being entered, so the registered outputs track the state register
    always_comb begin
        cmd_c = CMD_IDLE;
        if (next_ready) begin
            case (next_state)
                INIT_LO: begin
                    cmd_c.cs   = 1'b1;
                    cmd_c.rw   = 1'b0;
                    cmd_c.addr = ADDR_DIV_LO;
                    cmd_c.data = div_lo(cfg_sync);
                end
                INIT_HI: begin
                    cmd_c.cs   = 1'b1;
                    cmd_c.rw   = 1'b0;
                    cmd_c.addr = ADDR_DIV_HI;
                    cmd_c.data = div_hi(prog_cfg);
                end
                READ_RX: begin
                    cmd_c.cs   = 1'b1;
                    cmd_c.rw   = 1'b1;
                    cmd_c.addr = ADDR_BUF;
                end
                WRITE_TX: begin
                    cmd_c.cs   = 1'b1;
                    cmd_c.rw   = 1'b0;
                    cmd_c.addr = ADDR_BUF;
                    cmd_c.data = char_reg;
                end
                default: cmd_c = CMD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cmd_q <= CMD_IDLE;
        else      cmd_q <= cmd_c;
    end

    assign bus.iocs   = cmd_q.cs;
    assign bus.iorw   = cmd_q.rw;
    assign bus.ioaddr = cmd_q.addr;

    // Drive only on our own write cycles; the SPART owns the bus whenever iorw=1
    assign databus = (cmd_q.cs && !cmd_q.rw) ? cmd_q.data : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wake_q   <= 2'd0;
            prog_cfg <= '0;
            char_reg <= '0;
            pend     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (!ready) wake_q <= wake_q + 2'd1;

            if (next_ready && next_state == INIT_LO) prog_cfg <= cfg_sync;

            if (state == READ_RX) char_reg <= databus;

            if (next_state == READ_RX && state != READ_RX) pend <= 1'b0;
            else if (bus.rda && state != IDLE)             pend <= 1'b1;

            if (bus.rda && (pend || state == READ_RX)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: divisor programming per baud setting, echo path,
// transmitter back-pressure, overrun, live baud change and reset mid-write.
module tb_spart_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       overrun;
    logic [7:0] rx_buf;
    tri1  [7:0] databus;

    int n_checks = 0;
    int n_fail   = 0;

    spart_driver_if bus ();

    spart_driver dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .bus     (bus),
        .databus (databus),
        .overrun (overrun)
    );

    // SPART read mux model; with nobody driving, the pulled-up bus reads 0xFF
    assign databus = (bus.iocs && bus.iorw) ? rx_buf : 8'hzz;

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] cfg;
        logic [7:0] lo;
        logic [7:0] hi;
    } div_vec_t;

    div_vec_t vt [4];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic cs, input logic rw,
                           input logic [1:0] addr, input logic [7:0] data);
        chk({name, "_iocs"},    16'(bus.iocs),   16'(cs));
        chk({name, "_iorw"},    16'(bus.iorw),   16'(rw));
        chk({name, "_ioaddr"},  16'(bus.ioaddr), 16'(addr));
        chk({name, "_databus"}, 16'(databus),    16'(data));
    endtask

    task automatic wait_cs(input int bound, input string name);
        int i = 0;
        while (!bus.iocs && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_reached"}, 16'(bus.iocs), 16'd1);
    endtask

    task automatic wait_write(input int bound, input string name);
        int i = 0;
        while (!(bus.iocs && !bus.iorw) && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_reached"}, 16'(bus.iocs && !bus.iorw), 16'd1);
    endtask

    task automatic do_reset(input logic [1:0] cfg);
        @(negedge clk);
        rst      = 1'b0;
        br_cfg   = cfg;
        bus.rda  = 1'b0;
        bus.tbr  = 1'b1;
        repeat (2) @(negedge clk);
        chk_bus("reset", 1'b0, 1'b1, 2'b01, 8'hFF);
        chk("reset_overrun", 16'(overrun), 16'd0);
        rst = 1'b1;
    endtask

    initial begin
        logic stay_ok;

        rst     = 1'b0;
        br_cfg  = 2'b00;
        bus.rda = 1'b0;
        bus.tbr = 1'b1;
        rx_buf  = 8'h00;

        vt[0].cfg = 2'b00; vt[0].lo = 8'h16; vt[0].hi = 8'h05;
        vt[1].cfg = 2'b10; vt[1].lo = 8'h46; vt[1].hi = 8'h01;
        vt[2].cfg = 2'b11; vt[2].lo = 8'hA3; vt[2].hi = 8'h00;
        vt[3].cfg = 2'b01; vt[3].lo = 8'h8B; vt[3].hi = 8'h02;

        // Divisor programming after reset for every baud setting (ends at 9600)
        for (int v = 0; v < 4; v++) begin
            do_reset(vt[v].cfg);
            wait_cs(8, "init_lo");
            chk_bus("init_lo", 1'b1, 1'b0, 2'b10, vt[v].lo);
            @(negedge clk);
            chk_bus("init_hi", 1'b1, 1'b0, 2'b11, vt[v].hi);
            @(negedge clk);
            chk_bus("idle", 1'b0, 1'b1, 2'b01, 8'hFF);
        end

        // Basic echo with tbr=1: READ_RX at k+1, WRITE_TX at k+3, one-cycle write
        repeat (2) @(negedge clk);
        rx_buf = 8'h41; bus.tbr = 1'b1; bus.rda = 1'b1;
        @(negedge clk); bus.rda = 1'b0;
        chk_bus("echo_read", 1'b1, 1'b1, 2'b00, 8'h41);
        @(negedge clk);
        chk("echo_wait_iocs", 16'(bus.iocs), 16'd0);
        @(negedge clk);
        chk_bus("echo_write", 1'b1, 1'b0, 2'b00, 8'h41);
        @(negedge clk);
        chk("echo_write_one_cycle", 16'(bus.iocs), 16'd0);

        // Transmitter not ready for 50 cycles: hold in WAIT_TBR with bus released
        repeat (2) @(negedge clk);
        bus.tbr = 1'b0; rx_buf = 8'h41; bus.rda = 1'b1;
        @(negedge clk); bus.rda = 1'b0;
        chk_bus("hold_read", 1'b1, 1'b1, 2'b00, 8'h41);
        stay_ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (bus.iocs || !bus.iorw || databus !== 8'hFF) stay_ok = 1'b0;
        end
        chk("hold_wait_tbr", 16'(stay_ok), 16'd1);
        bus.tbr = 1'b1;
        @(negedge clk);
        chk_bus("hold_write", 1'b1, 1'b0, 2'b00, 8'h41);
        @(negedge clk);
        chk("hold_write_one_cycle", 16'(bus.iocs), 16'd0);

        // Two chars arrive while waiting on the transmitter: overrun, newer char echoed
        chk("pre_overrun", 16'(overrun), 16'd0);
        bus.tbr = 1'b0; rx_buf = 8'h33; bus.rda = 1'b1;
        @(negedge clk); bus.rda = 1'b0;
        @(negedge clk); rx_buf = 8'h41; bus.rda = 1'b1;
        @(negedge clk); bus.rda = 1'b0;
        chk("overrun_after_first", 16'(overrun), 16'd0);
        @(negedge clk); rx_buf = 8'h42; bus.rda = 1'b1;
        @(negedge clk); bus.rda = 1'b0;
        chk("overrun_set", 16'(overrun), 16'd1);
        bus.tbr = 1'b1;
        wait_write(6, "ovr_echo1");
        chk_bus("ovr_echo1", 1'b1, 1'b0, 2'b00, 8'h33);
        @(negedge clk);
        wait_write(8, "ovr_echo2");
        chk_bus("ovr_echo2", 1'b1, 1'b0, 2'b00, 8'h42);
        @(negedge clk);
        chk("ovr_idle_iocs", 16'(bus.iocs), 16'd0);

        // Baud change in IDLE: reprogram within 4 cycles
        br_cfg = 2'b11;
        wait_cs(4, "rebaud");
        chk_bus("rebaud_lo", 1'b1, 1'b0, 2'b10, 8'hA3);
        @(negedge clk);
        chk_bus("rebaud_hi", 1'b1, 1'b0, 2'b11, 8'h00);
        @(negedge clk);
        chk("rebaud_idle_iocs", 16'(bus.iocs), 16'd0);

        // Reset asserted in the middle of WRITE_TX
        repeat (2) @(negedge clk);
        bus.tbr = 1'b1; rx_buf = 8'h5A; bus.rda = 1'b1;
        @(negedge clk); bus.rda = 1'b0;
        wait_write(6, "rst_write");
        chk("rst_write_data", 16'(databus), 16'h005A);
        #2 rst = 1'b0;
        #1;
        chk_bus("rst_async", 1'b0, 1'b1, 2'b01, 8'hFF);
        @(negedge clk);
        chk("rst_overrun_clear", 16'(overrun), 16'd0);
        rst = 1'b1;
        wait_cs(8, "rst_reinit");
        chk_bus("rst_reinit_lo", 1'b1, 1'b0, 2'b10, 8'hA3);
        @(negedge clk);
        chk_bus("rst_reinit_hi", 1'b1, 1'b0, 2'b11, 8'h00);
        @(negedge clk);
        chk("rst_reinit_idle", 16'(bus.iocs), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_driver.md
SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 Parameter: none; baud divisors come from shared package constants for a 100 MHz clk.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 br_cfg  input  2  baud select from board switches: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-005 rda  input  1  SPART receive-data-available; a one-cycle pulse per received char.
REQ-006 tbr  input  1  SPART transmit-buffer-ready level.
REQ-007 iocs  output  1  SPART chip select, registered.
REQ-008 iorw  output  1  1=read, 0=write, registered.
REQ-009 ioaddr  output  2  00=TX/RX buffer, 01=status, 10=divisor low, 11=divisor high, registered.
REQ-010 databus  inout  8  driven by this block only when iocs=1 and iorw=0, else high-Z.
REQ-011 overrun  output  1  sticky flag: a char was received before the previous one was read.

Function
REQ-012 The block SHALL configure the SPART baud divisor, then echo every received char back to the transmitter.
REQ-013 The FSM SHALL have states INIT_LO, INIT_HI, IDLE, READ_RX, WAIT_TBR and WRITE_TX; the bus outputs are decoded from the registered state.
REQ-014 INIT_LO: iocs=1, iorw=0, ioaddr=10, databus=DIV[7:0]; next state INIT_HI.
REQ-015 INIT_HI: iocs=1, iorw=0, ioaddr=11, databus=DIV[15:8]; next state IDLE.
REQ-016 DIV values SHALL be 4800->1302 (0x0516), 9600->651 (0x028B), 19200->326 (0x0146), 38400->163 (0x00A3).
REQ-017 IDLE: iocs=0, iorw=1, ioaddr=01; go to READ_RX if rda=1 or pend=1; otherwise go to INIT_LO if the synchronized br_cfg differs from the last programmed value; otherwise stay.
REQ-018 br_cfg SHALL pass through a 2-flop synchronizer; the last programmed value is stored when INIT_LO is entered.
REQ-019 pend: sticky flag, set on rda=1 in any state other than IDLE; cleared when READ_RX is entered.
REQ-020 If rda=1 while pend=1 or while in READ_RX, overrun SHALL set, and the newer char is the one read.
REQ-021 READ_RX (one cycle): iocs=1, iorw=1, ioaddr=00; databus is latched into char_reg at the exiting edge; next state WAIT_TBR.
REQ-022 WAIT_TBR: iocs=0, iorw=1; go to WRITE_TX on the edge where tbr=1.
REQ-023 WRITE_TX (exactly one cycle): iocs=1, iorw=0, ioaddr=00, databus=char_reg; next state IDLE.
REQ-024 Latency: with tbr=1, rda high in cycle k gives READ_RX in k+1 and WRITE_TX in k+3.
REQ-025 A br_cfg change during an echo SHALL take effect only after returning to IDLE, with no pending char outstanding.
REQ-026 The block SHALL never drive databus while iorw=1, so no bus contention with the SPART read mux is possible.

Reset
REQ-027 On rst=0, the block SHALL force state=INIT_LO, iocs=0, iorw=1, ioaddr=01, char_reg=0, pend=0, overrun=0, programmed br_cfg=00, and synchronizer flops=00.
REQ-028 Reset mid-transaction SHALL abort the transaction immediately; after release, the divisor is reprogrammed from the current br_cfg.

Structure
REQ-029 A shared package SHALL hold the state enum, the ioaddr encodings (ADDR_BUF, ADDR_STATUS, ADDR_DIV_LO, ADDR_DIV_HI) and the four DIV constants with a br_cfg lookup function.
REQ-030 A single sub-module, br_sync, SHALL implement the 2-flop br_cfg synchronizer; everything else is flat.

Verification
REQ-031 Release reset with br_cfg=01 -> the bus shows write 10/0x8B, then write 11/0x02, then IDLE with iocs=0.
REQ-032 Pulse rda with SPART rx buffer=0x41 and tbr=1 -> READ_RX one cycle later, then WRITE_TX on 00 with databus=0x41, iocs high for exactly one cycle.
REQ-033 Hold tbr=0 for 50 cycles after READ_RX -> the block stays in WAIT_TBR with databus high-Z; when tbr rises, the write of 0x41 follows.
REQ-034 Pulse rda twice during WAIT_TBR (chars 0x41, 0x42) -> overrun=1, and the second echo sends 0x42.
REQ-035 Change br_cfg 01->11 in IDLE -> within 4 cycles the bus writes 10/0xA3, then 11/0x00.
REQ-036 Assert rst during WRITE_TX -> iocs=0 and databus high-Z asynchronously; after release, INIT_LO/INIT_HI repeat.
